// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : pipe_pkg
//  Description : Shared types and constants for pipeline-stage registers.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Encoding equals the number of entries held, so it doubles as occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
//  Interface   : pipe_stage_reg_if
//  Description : Valid/ready handshake bundle around one pipeline stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [1:0]        occupancy_o;

    // master: the environment around the stage (upstream producer + downstream consumer)
    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o,
        input  occupancy_o
    );

    // slave: the stage register itself
    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o,
        output occupancy_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_sat_counter
//  Description : Saturating event counter, synchronous active-low clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_counter #(
    parameter int CNT_W = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_n_i,
    input  wire logic             inc_i,
    output logic [CNT_W-1:0]      count_o
);
    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_max = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_count <= '0;
        end else if (inc_i && (r_count != c_max)) begin
            r_count <= r_count + c_one;
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Parametrised pipeline-stage register with valid/ready
//                handshake, 2-entry skid buffer, stall and flush controls.
//                Optional statistics counters: define PIPE_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  RESET_VAL = {DATA_W{1'b0}},
    parameter int                 CNT_W     = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_n_i,
    input  wire logic             stall_i,
    input  wire logic             flush_i,
    pipe_stage_reg_if.slave       bus
`ifdef PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
`endif
);
    import pipe_pkg::*;

    pipe_state_t       r_state;
    pipe_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_skid_nxt;

    logic w_in_ready;
    logic w_out_valid;
    logic w_in_fire;
    logic w_out_fire;
    logic w_flush_apply;

    // Ready depends only on registered state and stall, never on out_ready.
    assign w_in_ready    = (r_state != FULL)  & ~stall_i;
    assign w_out_valid   = (r_state != EMPTY) & ~stall_i;
    assign w_in_fire     = bus.in_valid_i & w_in_ready;
    assign w_out_fire    = w_out_valid & bus.out_ready_i;
    assign w_flush_apply = flush_i & ~stall_i;

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = w_out_valid;
    assign bus.out_data_o  = r_main;
    assign bus.occupancy_o = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (w_flush_apply) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = RESET_VAL;
            w_skid_nxt  = RESET_VAL;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = bus.in_data_i;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt  = bus.in_data_i;
                    end else if (w_in_fire) begin
                        w_state_nxt = FULL;
                        w_skid_nxt  = bus.in_data_i;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= EMPTY;
            r_main  <= RESET_VAL;
            r_skid  <= RESET_VAL;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

`ifdef PIPE_STATS_EN
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (stall_i),
        .count_o (stall_cnt_o)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (w_flush_apply),
        .count_o (flush_cnt_o)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Directed self-checking bench for pipe_stage_reg.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;
    localparam int          DW   = 64;
    localparam logic [63:0] BUB  = 64'h13;
    localparam int          CW   = 2;

    logic clk;
    logic rst_n;
    logic stall;
    logic flush;
    int   checks;
    int   errors;

    pipe_stage_reg_if #(.DATA_W(DW)) bus ();

`ifdef PIPE_STATS_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W    (DW),
        .RESET_VAL (BUB),
        .CNT_W     (CW)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .stall_i (stall),
        .flush_i (flush),
        .bus     (bus)
`ifdef PIPE_STATS_EN
        ,
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 64'hDEAD;
        bus.out_ready_i = 1'b0;

        // reset held for two edges with in_valid asserted
        tick();
        tick();
        check("rst_valid", {63'd0, bus.out_valid_o}, 64'd0);
        check("rst_data",  bus.out_data_o, BUB);
        check("rst_occ",   {62'd0, bus.occupancy_o}, 64'd0);
        check("rst_ready", {63'd0, bus.in_ready_o}, 64'd1);
        rst_n = 1'b1;
        bus.in_valid_i = 1'b0;
        tick();
        check("rel_occ",   {62'd0, bus.occupancy_o}, 64'd0);
        check("rel_ready", {63'd0, bus.in_ready_o}, 64'd1);

        // streaming with no back-pressure
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = 64'h10 + 64'(i);
            tick();
            check("str_valid", {63'd0, bus.out_valid_o}, 64'd1);
            check("str_data",  bus.out_data_o, 64'h10 + 64'(i));
            check("str_occ",   {62'd0, bus.occupancy_o}, 64'd1);
            check("str_ready", {63'd0, bus.in_ready_o}, 64'd1);
        end
        bus.in_valid_i = 1'b0;
        tick();
        check("str_drain_occ",   {62'd0, bus.occupancy_o}, 64'd0);
        check("str_drain_valid", {63'd0, bus.out_valid_o}, 64'd0);

        // back-pressure fills the skid entry
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 64'hA;
        tick();
        check("bp_occ1", {62'd0, bus.occupancy_o}, 64'd1);
        bus.in_data_i = 64'hB;
        tick();
        bus.in_valid_i = 1'b0;
        check("bp_occ2",   {62'd0, bus.occupancy_o}, 64'd2);
        check("bp_ready",  {63'd0, bus.in_ready_o}, 64'd0);
        check("bp_data_a", bus.out_data_o, 64'hA);
        check("bp_valid",  {63'd0, bus.out_valid_o}, 64'd1);
        bus.out_ready_i = 1'b1;
        tick();
        check("bp_data_b", bus.out_data_o, 64'hB);
        check("bp_occ_b",  {62'd0, bus.occupancy_o}, 64'd1);
        check("bp_ready_b", {63'd0, bus.in_ready_o}, 64'd1);
        tick();
        check("bp_occ0", {62'd0, bus.occupancy_o}, 64'd0);
        bus.out_ready_i = 1'b0;

        // flush while FULL, with a colliding input payload
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 64'h1;
        tick();
        bus.in_data_i  = 64'h2;
        tick();
        check("fl_full", {62'd0, bus.occupancy_o}, 64'd2);
        flush = 1'b1;
        bus.in_data_i = 64'hC;
        tick();
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        check("fl_occ",   {62'd0, bus.occupancy_o}, 64'd0);
        check("fl_valid", {63'd0, bus.out_valid_o}, 64'd0);
        check("fl_data",  bus.out_data_o, BUB);
        bus.out_ready_i = 1'b1;
        tick();
        check("fl_no_c_valid", {63'd0, bus.out_valid_o}, 64'd0);
        check("fl_no_c_data",  bus.out_data_o, BUB);
        bus.out_ready_i = 1'b0;

        // stall together with flush: stall wins
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 64'h55;
        tick();
        bus.in_valid_i = 1'b0;
        check("sf_load", bus.out_data_o, 64'h55);
        stall = 1'b1;
        flush = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 64'h66;
        bus.out_ready_i = 1'b1;
        #1;
        check("sf_ready0", {63'd0, bus.in_ready_o}, 64'd0);
        check("sf_valid0", {63'd0, bus.out_valid_o}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sf_ready", {63'd0, bus.in_ready_o}, 64'd0);
            check("sf_valid", {63'd0, bus.out_valid_o}, 64'd0);
            check("sf_data",  bus.out_data_o, 64'h55);
            check("sf_occ",   {62'd0, bus.occupancy_o}, 64'd1);
`ifdef PIPE_STATS_EN
            check("st_stall_cnt", {62'd0, stall_cnt}, 64'(i + 1));
`endif
        end
        stall = 1'b0;
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        #1;
        check("sf_deliver_valid", {63'd0, bus.out_valid_o}, 64'd1);
        check("sf_deliver_data",  bus.out_data_o, 64'h55);
        tick();
        check("sf_after_occ", {62'd0, bus.occupancy_o}, 64'd0);

        // two more stall cycles: 5 total, counter saturates at 3
        stall = 1'b1;
        tick();
        tick();
        stall = 1'b0;
`ifdef PIPE_STATS_EN
        check("st_stall_sat", {62'd0, stall_cnt}, 64'd3);
        check("st_flush_cnt", {62'd0, flush_cnt}, 64'd1);
`endif

        // reset mid-transfer drops held data
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 64'h77;
        tick();
        check("mr_occ_pre", {62'd0, bus.occupancy_o}, 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.in_valid_i = 1'b0;
        check("mr_occ",   {62'd0, bus.occupancy_o}, 64'd0);
        check("mr_data",  bus.out_data_o, BUB);
        check("mr_valid", {63'd0, bus.out_valid_o}, 64'd0);
`ifdef PIPE_STATS_EN
        check("mr_stall_cnt", {62'd0, stall_cnt}, 64'd0);
        check("mr_flush_cnt", {62'd0, flush_cnt}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline-stage register; successor to the fixed 32-bit pc/instr stage register.
- Sits between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake and a 2-entry skid buffer, so back-pressure gives full throughput without a combinational ready path through the stage.
- Keeps the legacy stall (freeze) and flush (bubble) controls and a configurable bubble value.

Parameters:
- DATA_W, 64, width of the payload carried through the stage (for example pc+instr = 64).
- RESET_VAL, {DATA_W{1'b0}}, payload value after reset and after a flush (the bubble, e.g. NOP encoding).
- CNT_W, 32, width of the statistics counters (used only with PIPE_STATS_EN).

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_n_i  in  1  reset, synchronous, active-low.
- stall_i  in  1  freeze: hold all state; mask the handshakes.
- flush_i  in  1  discard stage contents and insert a bubble.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept a payload.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  payload valid to downstream.
- out_ready_i  in  1  downstream accepts the payload.
- out_data_o  out  DATA_W  payload to downstream.
- occupancy_o  out  2  number of entries held (0, 1 or 2).
- stall_cnt_o  out  CNT_W  cycles with stall_i=1 (PIPE_STATS_EN only).
- flush_cnt_o  out  CNT_W  flushes applied (PIPE_STATS_EN only).

Behaviour:
- Reset: rst_n_i=0 at a posedge gives:
  - state=EMPTY;
  - main and skid registers = RESET_VAL;
  - counters = 0;
  - outputs: out_valid_o=0, out_data_o=RESET_VAL, occupancy_o=0, in_ready_o=1 (if stall_i=0).
  - Reset overrides stall_i and flush_i. Reset mid-transfer drops all held data.
- Handshake signals:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
  - in_ready_o = (state!=FULL) & ~stall_i. Combinational from state and stall_i only; never depends on in_valid_i or out_ready_i.
  - out_valid_o = (state!=EMPTY) & ~stall_i.
  - out_data_o = main register. It is held stable while out_valid_o=1 and out_ready_i=0.
- States (occupancy_o encodes them: EMPTY=0, ONE=1, FULL=2):
  - EMPTY:
    - in_fire -> ONE, main<=in_data_i.
  - ONE:
    - in_fire & out_fire -> ONE, main<=in_data_i.
    - in_fire & ~out_fire -> FULL, skid<=in_data_i.
    - ~in_fire & out_fire -> EMPTY.
    - otherwise hold.
  - FULL (in_ready_o=0):
    - out_fire -> ONE, main<=skid.
    - otherwise hold.
- Latency and ordering:
  - Latency is 1 cycle: a payload accepted at edge N is presented with out_valid_o=1 after edge N.
  - Order is strictly FIFO; no payload is duplicated or lost except by flush or reset.
- Flush:
  - flush_i=1 with stall_i=0 at a posedge gives state<=EMPTY and main, skid<=RESET_VAL.
  - A payload with in_fire in the same cycle is dropped.
  - An out_fire in the same cycle still counts as taken by downstream; the stage does not re-present it.
- Stall:
  - stall_i=1 holds all registers.
  - in_ready_o and out_valid_o are forced to 0, so no transfers occur.
  - out_data_o holds its value.
- stall_i and flush_i together: stall wins and the flush is ignored (same priority as the previous generation). Upstream must hold flush_i until stall_i drops.
- Width: the payload is opaque and is never modified except for replacement by RESET_VAL.

Optional Feature:
- Macro: PIPE_STATS_EN.
- Defined:
  - stall_cnt_o increments on every cycle with stall_i=1.
  - flush_cnt_o increments on every applied flush (flush_i=1 & stall_i=0).
  - Both saturate at all-ones, never wrap, and clear on reset.
- Undefined:
  - The counter ports and logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the state typedef pipe_state_t {EMPTY, ONE, FULL} with a 2-bit encoding equal to occupancy;
  - the localparam default NOP_INSTR (32'h0000_0013) that stages use for RESET_VAL.
- Sub-module pipe_sat_counter (CNT_W, inc_i, count_o) is natural. It is instantiated twice when PIPE_STATS_EN is defined.

Test Plan:
- Reset:
  - Stimulus: DATA_W=64, RESET_VAL=64'h13; hold rst_n_i=0 for 2 cycles with in_valid_i=1.
  - Response: out_valid_o=0, out_data_o=64'h13, occupancy_o=0, in_ready_o=1 after release.
- Streaming:
  - Stimulus: out_ready_i=1; in_valid_i=1 for 8 cycles with data 0x10..0x17.
  - Response: out_data_o shows 0x10..0x17 one cycle later with no bubbles; occupancy_o=1 throughout; in_ready_o never drops.
- Back-pressure:
  - Stimulus: out_ready_i=0; push 0xA then 0xB.
  - Response: occupancy_o=2, in_ready_o=0, out_data_o=0xA.
  - Stimulus: raise out_ready_i for 2 cycles.
  - Response: 0xA then 0xB delivered in order, then occupancy_o=0.
- Flush in FULL:
  - Stimulus: pulse flush_i with in_valid_i=1, data 0xC.
  - Response: next cycle occupancy_o=0, out_valid_o=0, out_data_o=RESET_VAL; 0xC never appears.
- Stall + flush:
  - Stimulus: state ONE holding 0x55; stall_i=1 and flush_i=1 for 3 cycles.
  - Response: in_ready_o=0, out_valid_o=0, out_data_o=0x55 throughout.
  - Stimulus: drop both.
  - Response: 0x55 is delivered, not flushed.
- Statistics (PIPE_STATS_EN, CNT_W=2):
  - Stimulus: 5 stall cycles and 1 applied flush.
  - Response: stall_cnt_o saturates at 3; flush_cnt_o=1.
